// File: rtl/flash_arb.sv
// Two-master round-robin arbiter in front of flash_ctrl: grants read/program/erase commands,
// drives one flash request until flash_ack, returns the result, then enforces a CS-idle gap.
module flash_arb #(
    parameter int unsigned GAP_CYC = 4,
    parameter int unsigned ADDR_W  = 24
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              m0_cmd_valid,
    input  logic [1:0]        m0_cmd_op,
    input  logic [ADDR_W-1:0] m0_cmd_addr,
    input  logic [7:0]        m0_cmd_wdata,
    output logic              m0_cmd_ready,
    output logic              m0_rsp_valid,
    output logic [7:0]        m0_rsp_rdata,
    output logic              m0_rsp_err,
    input  logic              m1_cmd_valid,
    input  logic [1:0]        m1_cmd_op,
    input  logic [ADDR_W-1:0] m1_cmd_addr,
    input  logic [7:0]        m1_cmd_wdata,
    output logic              m1_cmd_ready,
    output logic              m1_rsp_valid,
    output logic [7:0]        m1_rsp_rdata,
    output logic              m1_rsp_err,
    output logic              f_rd_req,
    output logic              f_pp_req,
    output logic              f_se_req,
    output logic [ADDR_W-1:0] f_addr,
    output logic [7:0]        f_wdata,
    input  logic              f_flash_ack,
    input  logic [7:0]        f_rdata,
    output logic              busy
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;

    localparam logic [1:0] OP_RD  = 2'b00;
    localparam logic [1:0] OP_RSV = 2'b11;

    // Terminal gap count; the GAP state is unreachable when GAP_CYC is 0.
    localparam logic [7:0] GAP_LAST = (GAP_CYC == 0) ? 8'd0 : 8'(GAP_CYC - 1);

    logic [1:0]             cmd_valid;
    logic [1:0][1:0]        cmd_op;
    logic [1:0][ADDR_W-1:0] cmd_addr;
    logic [1:0][7:0]        cmd_wdata;

    assign cmd_valid = {m1_cmd_valid, m0_cmd_valid};
    assign cmd_op    = {m1_cmd_op, m0_cmd_op};
    assign cmd_addr  = {m1_cmd_addr, m0_cmd_addr};
    assign cmd_wdata = {m1_cmd_wdata, m0_cmd_wdata};

    logic [1:0]        state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic [7:0]        gap_cnt_q, gap_cnt_d;
    logic              owner_q, owner_d;
    logic [1:0]        op_q, op_d;
    logic [2:0]        req_q, req_d;            // {se, pp, rd}
    logic [ADDR_W-1:0] f_addr_q, f_addr_d;
    logic [7:0]        f_wdata_q, f_wdata_d;
    logic              busy_q, busy_d;
    logic [1:0]        cmd_ready_q, cmd_ready_d;
    logic [1:0]        rsp_valid_q, rsp_valid_d;
    logic [1:0]        rsp_err_q, rsp_err_d;
    logic [1:0][7:0]   rsp_rdata_q, rsp_rdata_d;
    logic              grant;

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
        state_d      = state_q;
        last_grant_d = last_grant_q;
        gap_cnt_d    = gap_cnt_q;
        owner_d      = owner_q;
        op_d         = op_q;
        req_d        = req_q;
        f_addr_d     = f_addr_q;
        f_wdata_d    = f_wdata_q;
        cmd_ready_d  = 2'b00;
        rsp_valid_d  = 2'b00;
        rsp_err_d    = rsp_err_q;
        rsp_rdata_d  = rsp_rdata_q;
        grant        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (|cmd_valid) begin
                    // Contention goes to whoever was not served last.
                    grant              = (&cmd_valid) ? ~last_grant_q : cmd_valid[1];
                    last_grant_d       = grant;
                    cmd_ready_d[grant] = 1'b1;
                    if (cmd_op[grant] == OP_RSV) begin
                        rsp_valid_d[grant] = 1'b1;
                        rsp_err_d[grant]   = 1'b1;
                        rsp_rdata_d[grant] = 8'h00;
                    end else begin
                        owner_d   = grant;
                        op_d      = cmd_op[grant];
                        f_addr_d  = cmd_addr[grant];
                        f_wdata_d = cmd_wdata[grant];
                        req_d     = 3'b001 << cmd_op[grant];
                        state_d   = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (f_flash_ack) begin
                    // Drop the request on the ack edge so flash_ctrl cannot relaunch from IDLE.
                    req_d                = 3'b000;
                    rsp_valid_d[owner_q] = 1'b1;
                    rsp_err_d[owner_q]   = 1'b0;
                    rsp_rdata_d[owner_q] = (op_q == OP_RD) ? f_rdata : 8'h00;
                    if (GAP_CYC != 0) begin
                        state_d   = S_GAP;
                        gap_cnt_d = 8'd0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 8'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            gap_cnt_q    <= 8'd0;
            owner_q      <= 1'b0;
            op_q         <= 2'b00;
            req_q        <= 3'b000;
            f_addr_q     <= '0;
            f_wdata_q    <= 8'h00;
            busy_q       <= 1'b0;
            cmd_ready_q  <= 2'b00;
            rsp_valid_q  <= 2'b00;
            rsp_err_q    <= 2'b00;
            rsp_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            gap_cnt_q    <= gap_cnt_d;
            owner_q      <= owner_d;
            op_q         <= op_d;
            req_q        <= req_d;
            f_addr_q     <= f_addr_d;
            f_wdata_q    <= f_wdata_d;
            busy_q       <= busy_d;
            cmd_ready_q  <= cmd_ready_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_err_q    <= rsp_err_d;
            rsp_rdata_q  <= rsp_rdata_d;
        end
    end

    assign m0_cmd_ready = cmd_ready_q[0];
    assign m0_rsp_valid = rsp_valid_q[0];
    assign m0_rsp_rdata = rsp_rdata_q[0];
    assign m0_rsp_err   = rsp_err_q[0];
    assign m1_cmd_ready = cmd_ready_q[1];
    assign m1_rsp_valid = rsp_valid_q[1];
    assign m1_rsp_rdata = rsp_rdata_q[1];
    assign m1_rsp_err   = rsp_err_q[1];
    assign f_rd_req     = req_q[0];
    assign f_pp_req     = req_q[1];
    assign f_se_req     = req_q[2];
    assign f_addr       = f_addr_q;
    assign f_wdata      = f_wdata_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_flash_arb.sv
// Bench for flash_arb: a GAP_CYC=4 and a GAP_CYC=0 instance, each with a flash model,
// checked every cycle against a transaction-level model plus directed scenarios.
module tb_flash_arb;

    localparam int GAP0 = 4;

    logic clk;
    logic reset_n;

    logic [1:0][1:0]       cv;
    logic [1:0][1:0][1:0]  cop;
    logic [1:0][1:0][23:0] cad;
    logic [1:0][1:0][7:0]  cwd;
    logic [1:0][1:0]       rdy, rv, rer;
    logic [1:0][1:0][7:0]  rdt;
    logic [1:0]            rrq, prq, srq, bsy, ack;
    logic [1:0][23:0]      fa;
    logic [1:0][7:0]       fw, frd;
    logic [1:0]            fbz;
    logic [1:0][2:0]       fcnt;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int rate  = 0;
    logic [1:0] auto_on;

    // Reference model state (phase 0 free, 1 flash op in flight, 2 gap)
    int         ph[2], rem[2], last[2], own[2], gap_len[2];
    logic [1:0] cur_op[2];
    logic [23:0] cur_addr[2];
    logic [7:0]  cur_wd[2];
    logic [7:0]  exp_rd[2][2];
    logic [1:0]       ack_cur;
    logic [1:0][7:0]  frd_cur;

    for (genvar k = 0; k < 2; k++) begin : g_dut
        flash_arb #(.GAP_CYC(k == 0 ? GAP0 : 0), .ADDR_W(24)) u_dut (
            .clk          (clk),
            .reset_n      (reset_n),
            .m0_cmd_valid (cv[k][0]),
            .m0_cmd_op    (cop[k][0]),
            .m0_cmd_addr  (cad[k][0]),
            .m0_cmd_wdata (cwd[k][0]),
            .m0_cmd_ready (rdy[k][0]),
            .m0_rsp_valid (rv[k][0]),
            .m0_rsp_rdata (rdt[k][0]),
            .m0_rsp_err   (rer[k][0]),
            .m1_cmd_valid (cv[k][1]),
            .m1_cmd_op    (cop[k][1]),
            .m1_cmd_addr  (cad[k][1]),
            .m1_cmd_wdata (cwd[k][1]),
            .m1_cmd_ready (rdy[k][1]),
            .m1_rsp_valid (rv[k][1]),
            .m1_rsp_rdata (rdt[k][1]),
            .m1_rsp_err   (rer[k][1]),
            .f_rd_req     (rrq[k]),
            .f_pp_req     (prq[k]),
            .f_se_req     (srq[k]),
            .f_addr       (fa[k]),
            .f_wdata      (fw[k]),
            .f_flash_ack  (ack[k]),
            .f_rdata      (frd[k]),
            .busy         (bsy[k])
        );
    end

    always #5 clk = ~clk;

    function automatic logic [7:0] fdata(logic [23:0] a);
        return a[7:0] + a[15:8] + 8'h3D;
    endfunction

    // Flash model: after a random latency, pulses ack with read data while a request is held.
    always @(posedge clk or negedge reset_n) begin
        for (int k = 0; k < 2; k++) begin
            if (!reset_n) begin
                ack[k]  <= 1'b0;
                fbz[k]  <= 1'b0;
                fcnt[k] <= 3'd0;
                frd[k]  <= 8'h00;
            end else begin
                ack[k] <= 1'b0;
                if (fbz[k]) begin
                    if (fcnt[k] == 3'd0) begin
                        ack[k] <= 1'b1;
                        fbz[k] <= 1'b0;
                        frd[k] <= fdata(fa[k]);
                    end else begin
                        fcnt[k] <= fcnt[k] - 3'd1;
                    end
                end else if ((rrq[k] | prq[k] | srq[k]) && !ack[k]) begin
                    fbz[k]  <= 1'b1;
                    fcnt[k] <= 3'($urandom_range(0, 3));
                end
            end
        end
    end

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic set_cmd(int k, int m, logic [1:0] op, logic [23:0] a, logic [7:0] w);
        cv[k][m]  = 1'b1;
        cop[k][m] = op;
        cad[k][m] = a;
        cwd[k][m] = w;
    endtask

    task automatic new_cmd(int k, int m);
        int r;
        r = $urandom_range(0, 9);
        set_cmd(k, m, (r < 3) ? 2'b00 : (r < 6) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11,
                24'($urandom), 8'($urandom));
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            ph[k] = 0; rem[k] = 0; last[k] = 1; own[k] = 0;
            cur_op[k] = 2'b00; cur_addr[k] = 24'h0; cur_wd[k] = 8'h0;
            exp_rd[k][0] = 8'h00; exp_rd[k][1] = 8'h00;
        end
        ack_cur = '0;
        frd_cur = '0;
    endtask

    // Predict this cycle's outputs from the inputs and flash ack of the cycle that just ended.
    task automatic model_check(int k);
        logic [1:0] e_rdy, e_rv, e_err;
        logic [2:0] e_req;
        int m;
        e_rdy = 2'b00; e_rv = 2'b00; e_err = 2'b00;
        if (ph[k] == 0) begin
            if (cv[k] != 2'b00) begin
                m = (cv[k] == 2'b11) ? 1 - last[k] : (cv[k][0] ? 0 : 1);
                last[k] = m;
                e_rdy[m] = 1'b1;
                if (cop[k][m] == 2'b11) begin
                    e_rv[m] = 1'b1; e_err[m] = 1'b1; exp_rd[k][m] = 8'h00;
                end else begin
                    ph[k] = 1; own[k] = m; cur_op[k] = cop[k][m];
                    cur_addr[k] = cad[k][m]; cur_wd[k] = cwd[k][m];
                end
            end
        end else if (ph[k] == 1) begin
            if (ack_cur[k]) begin
                e_rv[own[k]] = 1'b1;
                exp_rd[k][own[k]] = (cur_op[k] == 2'b00) ? frd_cur[k] : 8'h00;
                rem[k] = gap_len[k];
                ph[k] = (gap_len[k] > 0) ? 2 : 0;
            end
        end else begin
            rem[k]--;
            if (rem[k] == 0) ph[k] = 0;
        end
        e_req = (ph[k] == 1) ? 3'(3'b001 << cur_op[k]) : 3'b000;
        check($sformatf("ctl%0d", k), {rdy[k], rv[k], srq[k], prq[k], rrq[k], bsy[k]},
              {e_rdy, e_rv, e_req, ph[k] != 0});
        check($sformatf("onehot%0d", k), $onehot0({srq[k], prq[k], rrq[k]}), 1);
        for (int j = 0; j < 2; j++) begin
            check($sformatf("rdata%0d_m%0d", k, j), rdt[k][j], exp_rd[k][j]);
            if (e_rv[j]) check($sformatf("err%0d_m%0d", k, j), rer[k][j], e_err[j]);
        end
        if (ph[k] == 1) begin
            check($sformatf("faddr%0d", k), fa[k], cur_addr[k]);
            check($sformatf("fwdata%0d", k), fw[k], cur_wd[k]);
        end
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        #1;
        for (int k = 0; k < 2; k++) model_check(k);
        for (int k = 0; k < 2; k++) begin
            for (int m = 0; m < 2; m++) begin
                if (rdy[k][m]) cv[k][m] = 1'b0;
                if (!cv[k][m] && auto_on[k] && $urandom_range(0, 99) < rate) new_cmd(k, m);
            end
            ack_cur[k] = ack[k];
            frd_cur[k] = frd[k];
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        cv = '0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        int ack_e;
        int grants[$];
        clk = 1'b0; reset_n = 1'b0;
        cv = '0; cop = '0; cad = '0; cwd = '0; auto_on = 2'b00;
        gap_len[0] = GAP0; gap_len[1] = 0;
        do_reset();

        // Reset state
        for (int k = 0; k < 2; k++) begin
            check($sformatf("rst_ctl%0d", k), {rdy[k], rv[k], srq[k], prq[k], rrq[k], bsy[k]}, 0);
            check($sformatf("rst_bus%0d", k), {fa[k], fw[k], rdt[k], rer[k]}, 0);
        end

        // 1: m0 read
        set_cmd(0, 0, 2'b00, 24'h012345, 8'h00);
        step();
        check("t1_ready", rdy[0][0], 1);
        check("t1_rdreq", rrq[0], 1);
        check("t1_addr", fa[0], 24'h012345);
        for (int i = 0; i < 50 && !rv[0][0]; i++) step();
        check("t1_rsp", rv[0][0], 1);
        check("t1_rdata", rdt[0][0], 8'hA5);
        check("t1_err", rer[0][0], 0);

        // 2: simultaneous m0 PP and m1 SE after reset
        do_reset();
        set_cmd(0, 0, 2'b01, 24'h00A000, 8'h5C);
        set_cmd(0, 1, 2'b10, 24'h030000, 8'h00);
        step();
        check("t2_ready", rdy[0], 2'b01);
        check("t2_ppreq", {srq[0], prq[0], rrq[0]}, 3'b010);
        check("t2_wdata", fw[0], 8'h5C);
        for (int i = 0; i < 50 && !rv[0][0]; i++) step();
        check("t2_rsp0", rv[0][0], 1);
        ack_e = cyc;
        for (int i = 0; i < 30 && !srq[0]; i++) step();
        check("t2_gap", cyc - ack_e, GAP0 + 1);
        check("t2_ready1", rdy[0][1], 1);
        for (int i = 0; i < 50 && !rv[0][1]; i++) step();
        check("t2_rsp1", rv[0][1], 1);
        check("t2_rdata1", rdt[0][1], 8'h00);

        // 3: both masters continuously valid -> alternating grants starting with m0
        rate = 100;
        auto_on = 2'b01;
        for (int i = 0; i < 400 && grants.size() < 6; i++) begin
            step();
            for (int m = 0; m < 2; m++) if (rdy[0][m]) grants.push_back(m);
        end
        check("t3_count", grants.size(), 6);
        for (int i = 0; i < grants.size() && i < 6; i++)
            check($sformatf("t3_grant%0d", i), grants[i], i % 2);
        auto_on = 2'b00;
        for (int i = 0; i < 200 && (cv != '0 || ph[0] != 0 || ph[1] != 0); i++) step();
        check("t3_drain", ph[0], 0);

        // 4: reserved op from m1
        set_cmd(0, 1, 2'b11, 24'h000777, 8'h11);
        step();
        check("t4_ready", rdy[0], 2'b10);
        check("t4_rsp", rv[0], 2'b10);
        check("t4_err", rer[0][1], 1);
        check("t4_rdata", rdt[0][1], 8'h00);
        check("t4_quiet", {srq[0], prq[0], rrq[0], bsy[0]}, 0);
        step();
        check("t4_quiet2", {srq[0], prq[0], rrq[0], bsy[0]}, 0);

        // 5: reset during a program op, then a fresh read
        set_cmd(0, 0, 2'b01, 24'h004400, 8'h99);
        step();
        check("t5_ppreq", prq[0], 1);
        #2 reset_n = 1'b0;
        #1;
        check("t5_async", {prq[0], rrq[0], srq[0], bsy[0], rv[0], rdy[0]}, 0);
        do_reset();
        set_cmd(0, 0, 2'b00, 24'h00BEEF, 8'h00);
        step();
        check("t5_rdreq", rrq[0], 1);
        for (int i = 0; i < 50 && !rv[0][0]; i++) step();
        check("t5_rsp", rv[0][0], 1);
        check("t5_rdata", rdt[0][0], fdata(24'h00BEEF));

        // 6: GAP_CYC=0 instance, pending m1 read behind m0
        set_cmd(1, 0, 2'b00, 24'h111111, 8'h00);
        step();
        set_cmd(1, 1, 2'b00, 24'h222222, 8'h00);
        for (int i = 0; i < 50 && !rv[1][0]; i++) step();
        check("t6_rsp0", rv[1][0], 1);
        check("t6_idle", {rrq[1], rdy[1][1]}, 0);
        step();
        check("t6_rdreq", {rrq[1], rdy[1][1]}, 2'b11);
        check("t6_addr", fa[1], 24'h222222);
        for (int i = 0; i < 50 && !rv[1][1]; i++) step();
        check("t6_rdata", rdt[1][1], fdata(24'h222222));

        // Random traffic on both instances
        rate = 30;
        auto_on = 2'b11;
        repeat (3000) step();
        auto_on = 2'b00;
        for (int i = 0; i < 300 && (cv != '0 || ph[0] != 0 || ph[1] != 0); i++) step();
        check("rnd_drain", {cv, 2'(ph[0]), 2'(ph[1])}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
